// File: rtl/bcd_disp_pkg.sv
// rtl/bcd_disp_pkg.sv - shared digit/segment types and seven-segment glyph constants
package bcd_disp_pkg;

  typedef logic [3:0] bcd_digit_t;
  typedef logic [6:0] seg7_t;

  // Glyphs are active-high {g,f,e,d,c,b,a}; pin polarity is applied at the top level
  localparam seg7_t SEG_0     = 7'h3F;
  localparam seg7_t SEG_1     = 7'h06;
  localparam seg7_t SEG_2     = 7'h5B;
  localparam seg7_t SEG_3     = 7'h4F;
  localparam seg7_t SEG_4     = 7'h66;
  localparam seg7_t SEG_5     = 7'h6D;
  localparam seg7_t SEG_6     = 7'h7D;
  localparam seg7_t SEG_7     = 7'h07;
  localparam seg7_t SEG_8     = 7'h7F;
  localparam seg7_t SEG_9     = 7'h6F;
  localparam seg7_t SEG_DASH  = 7'h40;
  localparam seg7_t SEG_BLANK = 7'h00;

endpackage

// File: rtl/bcd_to_seg7.sv
// rtl/bcd_to_seg7.sv - combinational BCD digit to active-high seven-segment decoder with blank
module bcd_to_seg7
  import bcd_disp_pkg::*;
(
  input  bcd_digit_t digit,
  input  logic       blank,
  output seg7_t      seg
);

  // Blank overrides the glyph; codes 10..15 render as a dash so bad data is visible
  always_comb begin
    seg = SEG_BLANK;
    if (!blank) begin
      case (digit)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_DASH;
      endcase
    end
  end

endmodule

// File: rtl/bcd_display_scan.sv
// rtl/bcd_display_scan.sv - tear-free multiplexed seven-segment scanner; option macro BCD_LEADING_ZERO_BLANK_EN
module bcd_display_scan
  import bcd_disp_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_DIV    = 1000,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic                    load,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_start,
  output logic                    load_pending
);

  localparam int TW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [TW-1:0] TICK_LAST = TW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

  logic [TW-1:0]           tick_cnt;
  logic [IW-1:0]           dig_idx;
  logic [4*NUM_DIGITS-1:0] staging;
  logic [4*NUM_DIGITS-1:0] shadow;
  logic                    tick;
  logic                    frame_bnd;
  logic [NUM_DIGITS-1:0]   blank_mask;
  logic [NUM_DIGITS-1:0]   an_dec;
  bcd_digit_t              cur_digit;
  seg7_t                   seg_dec;

  assign tick      = (tick_cnt == TICK_LAST);
  assign frame_bnd = tick && (dig_idx == IDX_LAST);

  // Refresh prescaler and digit rotation
  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt <= '0;
      dig_idx  <= '0;
    end else begin
      tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
      if (tick) dig_idx <= (dig_idx == IDX_LAST) ? '0 : dig_idx + 1'b1;
    end
  end

  // Staging/shadow handshake: the shadow only changes at a frame boundary so a frame never mixes values
  always_ff @(posedge clk) begin
    if (reset) begin
      staging      <= '0;
      shadow       <= '0;
      load_pending <= 1'b0;
      frame_start  <= 1'b0;
    end else begin
      frame_start <= frame_bnd;
      if (load && frame_bnd) begin
        staging      <= bcd_in;
        shadow       <= bcd_in;
        load_pending <= 1'b0;
      end else if (load) begin
        staging      <= bcd_in;
        load_pending <= 1'b1;
      end else if (frame_bnd && load_pending) begin
        shadow       <= staging;
        load_pending <= 1'b0;
      end
    end
  end

`ifdef BCD_LEADING_ZERO_BLANK_EN
  logic seen_nz;

  // Walk from the most significant digit down; zeros above the first nonzero digit go blank
  always_comb begin
    seen_nz    = 1'b0;
    blank_mask = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      if (shadow[4*i +: 4] != 4'd0) seen_nz = 1'b1;
      blank_mask[i] = !seen_nz && (i != 0);
    end
  end
`else
  // Every digit is shown as decoded, leading zeros included
  always_comb begin
    blank_mask = '0;
  end
`endif

  assign cur_digit = shadow[{dig_idx, 2'b00} +: 4];

  bcd_to_seg7 u_dec (
    .digit (cur_digit),
    .blank (blank_mask[dig_idx]),
    .seg   (seg_dec)
  );

  // One-hot enable for the digit currently being scanned
  always_comb begin
    an_dec          = '0;
    an_dec[dig_idx] = 1'b1;
  end

  // Registered pin drive with polarity applied; inactive while in reset
  always_ff @(posedge clk) begin
    if (reset) begin
      seg <= SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
      an  <= {NUM_DIGITS{SEG_ACTIVE_LOW}};
    end else begin
      seg <= SEG_ACTIVE_LOW ? ~seg_dec : seg_dec;
      an  <= SEG_ACTIVE_LOW ? ~an_dec : an_dec;
    end
  end

endmodule

// File: tb/tb_bcd_display_scan.sv
// tb/tb_bcd_display_scan.sv - directed scoreboard bench for bcd_display_scan
module tb_bcd_display_scan;

  localparam int ND = 4;
  localparam int RD = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load = 1'b0;
  logic [15:0] bcd_in = 16'h0;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        frame_start;
  logic        load_pending;

  bcd_display_scan #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .SEG_ACTIVE_LOW(1'b1)) dut (
    .clk          (clk),
    .reset        (reset),
    .bcd_in       (bcd_in),
    .load         (load),
    .seg          (seg),
    .an           (an),
    .frame_start  (frame_start),
    .load_pending (load_pending)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0] seg;
    logic [3:0] an;
    logic       fs;
    logic       lp;
  } exp_t;

  exp_t        q[$];
  int          vecs = 0;
  int          errs = 0;
  int          n = 0;
  logic [15:0] sh_m = 16'h0;
  logic [15:0] st_m = 16'h0;
  logic        pd_m = 1'b0;

  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'd0: return 7'h3F;
      4'd1: return 7'h06;
      4'd2: return 7'h5B;
      4'd3: return 7'h4F;
      4'd4: return 7'h66;
      4'd5: return 7'h6D;
      4'd6: return 7'h7D;
      4'd7: return 7'h07;
      4'd8: return 7'h7F;
      4'd9: return 7'h6F;
      default: return 7'h40;
    endcase
  endfunction

  function automatic logic [6:0] exp_seg(input logic [15:0] v, input int idx);
`ifdef BCD_LEADING_ZERO_BLANK_EN
    logic lead;
    lead = (idx != 0);
    for (int j = idx; j < ND; j++) if (v[j*4 +: 4] != 4'd0) lead = 1'b0;
    if (lead) return 7'h7F;
`endif
    return ~glyph(v[idx*4 +: 4]);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vecs++;
    assert (obs === expv) else begin
      errs++;
      $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, n, obs, expv);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    load  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("rst_seg", 32'(seg), 32'h7F);
      chk("rst_an", 32'(an), 32'hF);
      chk("rst_lp", 32'(load_pending), 32'h0);
      chk("rst_fs", 32'(frame_start), 32'h0);
    end
    reset = 1'b0;
    n     = 0;
    sh_m  = 16'h0;
    st_m  = 16'h0;
    pd_m  = 1'b0;
  endtask

  task automatic step(input logic l, input logic [15:0] v);
    exp_t e;
    logic bnd;
    int   idx;
    @(negedge clk);
    load   = l;
    bcd_in = v;
    bnd    = ((n + 1) % 16) == 0;
    idx    = (n / 4) % 4;
    e.seg  = exp_seg(sh_m, idx);
    e.an   = ~(4'(1) << idx);
    e.fs   = bnd;
    if (l && bnd) begin
      sh_m = v; st_m = v; pd_m = 1'b0;
    end else if (l) begin
      st_m = v; pd_m = 1'b1;
    end else if (bnd && pd_m) begin
      sh_m = st_m; pd_m = 1'b0;
    end
    e.lp = pd_m;
    q.push_back(e);
    @(posedge clk);
    n++;
    #1;
    e = q.pop_front();
    chk("seg", 32'(seg), 32'(e.seg));
    chk("an", 32'(an), 32'(e.an));
    chk("frame_start", 32'(frame_start), 32'(e.fs));
    chk("load_pending", 32'(load_pending), 32'(e.lp));
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(1'b0, 16'h0);
  endtask

  task automatic idle_until(input int r);
    for (int i = 0; i < 16 && ((n + 1) % 16) != r; i++) step(1'b0, 16'h0);
  endtask

  initial begin
    do_reset();
    idle(34);

    do_reset();
    idle(4);
    step(1'b1, 16'h1234);
    idle(40);

    idle_until(5);
    step(1'b1, 16'h1111);
    idle(3);
    step(1'b1, 16'h5678);
    idle_until(0);
    step(1'b1, 16'h9999);
    idle(20);

    step(1'b1, 16'h00A0);
    idle(36);

    step(1'b1, 16'h0050);
    idle(36);
    step(1'b1, 16'h0000);
    idle(36);

    idle_until(3);
    step(1'b1, 16'h4321);
    do_reset();
    idle(36);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout cycle=%0d", n);
    $fatal(1, "timeout");
  end

endmodule
